// File: rtl/csa_stream_accumulator.sv
// Streaming group accumulator: each beat's lanes are folded into a redundant
// carry-save pair, and one carry-propagate add resolves the pair at group end.
module csa_stream_accumulator #(
  parameter int IN_WIDTH  = 18,
  parameter int LANES     = 3,
  parameter int ACC_WIDTH = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*IN_WIDTH-1:0] in_data,
  input  logic                      in_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ACC_WIDTH-1:0]      out_sum,
  output logic [CNT_WIDTH-1:0]      out_count
);

  typedef enum logic [1:0] {ACCUM, RESOLVE, OUTPUT} state_t;

  state_t               state;
  logic [ACC_WIDTH-1:0] acc_s;
  logic [ACC_WIDTH-1:0] acc_c;
  logic [ACC_WIDTH-1:0] nxt_s;
  logic [ACC_WIDTH-1:0] nxt_c;
  logic [CNT_WIDTH-1:0] cnt;

  function automatic logic [ACC_WIDTH-1:0] csa_sum(input logic [ACC_WIDTH-1:0] a,
                                                   input logic [ACC_WIDTH-1:0] b,
                                                   input logic [ACC_WIDTH-1:0] c);
    return a ^ b ^ c;
  endfunction

  // Carry weight is one bit higher; the shift drops anything past the top bit.
  function automatic logic [ACC_WIDTH-1:0] csa_carry(input logic [ACC_WIDTH-1:0] a,
                                                     input logic [ACC_WIDTH-1:0] b,
                                                     input logic [ACC_WIDTH-1:0] c);
    return ((a & b) | (a & c) | (b & c)) << 1;
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_comb begin
    logic [ACC_WIDTH-1:0] op;
    logic [ACC_WIDTH-1:0] ts;
    logic [ACC_WIDTH-1:0] tc;
    nxt_s = acc_s;
    nxt_c = acc_c;
    op    = '0;
    ts    = '0;
    tc    = '0;
    for (int k = 0; k < LANES; k++) begin
      op    = {{(ACC_WIDTH-IN_WIDTH){1'b0}}, in_data[k*IN_WIDTH +: IN_WIDTH]};
      ts    = csa_sum(nxt_s, nxt_c, op);
      tc    = csa_carry(nxt_s, nxt_c, op);
      nxt_s = ts;
      nxt_c = tc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ACCUM;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      acc_s     <= '0;
      acc_c     <= '0;
      cnt       <= '0;
      out_sum   <= '0;
      out_count <= '0;
    end else begin
      case (state)
        ACCUM: begin
          if (in_valid && in_ready) begin
            acc_s <= nxt_s;
            acc_c <= nxt_c;
            cnt   <= sat_inc(cnt);
            if (in_last) begin
              state    <= RESOLVE;
              in_ready <= 1'b0;
            end
          end
        end
        // The only carry-propagate add in the block happens here, once per group.
        RESOLVE: begin
          out_sum   <= acc_s + acc_c;
          out_count <= cnt;
          acc_s     <= '0;
          acc_c     <= '0;
          cnt       <= '0;
          state     <= OUTPUT;
          out_valid <= 1'b1;
        end
        OUTPUT: begin
          if (out_ready) begin
            state     <= ACCUM;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= ACCUM;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_csa_stream_accumulator.sv
// Scoreboard bench: a plain-adder model pushes expected group results, which are
// popped and compared when the 32-bit and 20-bit accumulators present them.
module tb_csa_stream_accumulator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [53:0] in_data = '0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b1;
  logic        in_ready, out_valid;
  logic [31:0] out_sum;
  logic [15:0] out_count;
  logic        in_ready2, out_valid2;
  logic [19:0] out_sum2;
  logic [15:0] out_count2;

  typedef struct {
    logic [31:0] s32;
    logic [19:0] s20;
    logic [15:0] cnt;
  } exp_t;

  exp_t        q[$];
  logic [31:0] m32 = '0;
  logic [19:0] m20 = '0;
  logic [15:0] mcnt = '0;
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          acc_cyc = 0;

  csa_stream_accumulator #(.IN_WIDTH(18), .LANES(3), .ACC_WIDTH(32), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_count(out_count)
  );

  csa_stream_accumulator #(.IN_WIDTH(18), .LANES(3), .ACC_WIDTH(20), .CNT_WIDTH(16)) dut20 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
    .in_last(in_last), .out_valid(out_valid2), .out_ready(out_ready),
    .out_sum(out_sum2), .out_count(out_count2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, time=%0t required=<300000", $time);
    $fatal(1);
  end

  task automatic clear_model();
    m32 = '0;
    m20 = '0;
    mcnt = '0;
  endtask

  task automatic send_beat(input logic [17:0] a, input logic [17:0] b, input logic [17:0] c,
                           input logic last);
    bit ok;
    int n;
    ok = 0;
    n = 0;
    in_valid = 1'b1;
    in_data  = {c, b, a};
    in_last  = last;
    while (!ok && n < 50) begin
      if (in_ready) ok = 1;
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL send_beat: beat not accepted, in_ready=%0b required=1", in_ready);
    end else begin
      acc_cyc = cyc;
      m32 = m32 + a + b + c;
      m20 = m20 + a + b + c;
      mcnt++;
      if (last) begin
        q.push_back('{s32: m32, s20: m20, cnt: mcnt});
        clear_model();
      end
    end
  endtask

  task automatic wait_valid(output bit ok);
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    ok = out_valid;
  endtask

  task automatic wait_result(input string name);
    bit   ok;
    exp_t e;
    wait_valid(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s timeout: out_valid=%0b required=1", name, out_valid);
      return;
    end
    if (q.size() == 0) begin
      errors++;
      $display("FAIL %s unexpected result: sum=%0d with empty scoreboard", name, out_sum);
    end else begin
      e = q.pop_front();
      if (out_sum !== e.s32 || out_count !== e.cnt) begin
        errors++;
        $display("FAIL %s: sum=%0d count=%0d required sum=%0d count=%0d",
                 name, out_sum, out_count, e.s32, e.cnt);
      end
      checks++;
      if (out_valid2 !== 1'b1 || out_sum2 !== e.s20 || out_count2 !== e.cnt) begin
        errors++;
        $display("FAIL %s acc20: valid=%0b sum=%0d count=%0d required valid=1 sum=%0d count=%0d",
                 name, out_valid2, out_sum2, out_count2, e.s20, e.cnt);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || out_sum !== 32'd0 || out_count !== 16'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset: valid=%0b sum=%0d count=%0d ready=%0b required 0 0 0 1",
               out_valid, out_sum, out_count, in_ready);
    end
  endtask

  task automatic test_single();
    send_beat(18'd1, 18'd2, 18'd3, 1'b1);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single latency t+1: out_valid=%0b required=0", out_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || out_sum !== 32'd6) begin
      errors++;
      $display("FAIL single latency t+2: valid=%0b sum=%0d required valid=1 sum=6", out_valid, out_sum);
    end
    wait_result("single");
  endtask

  task automatic test_idle();
    for (int i = 0; i < 4; i++) begin
      send_beat(18'h3FFFF, 18'h3FFFF, 18'h3FFFF, i == 3);
      if (i < 3) begin
        in_data = 54'({$urandom, $urandom});
        in_last = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        in_last = 1'b0;
      end
    end
    wait_result("idle_max");
  endtask

  task automatic test_backpressure();
    bit ok;
    out_ready = 1'b0;
    send_beat(18'd1, 18'd1, 18'd1, 1'b1);
    wait_valid(ok);
    in_valid = 1'b1;
    in_data  = {18'd9, 18'd9, 18'd9};
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || q.size() == 0 ||
          out_sum !== q[0].s32 || out_count !== q[0].cnt) begin
        errors++;
        $display("FAIL backpressure hold %0d: valid=%0b ready=%0b sum=%0d count=%0d required valid=1 ready=0 sum=3 count=1",
                 i, out_valid, in_ready, out_sum, out_count);
      end
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    wait_result("backpressure");
    send_beat(18'd7, 18'd0, 18'd0, 1'b1);
    wait_result("after_backpressure");
  endtask

  task automatic test_wrap();
    bit ok;
    for (int i = 0; i < 5; i++) send_beat(18'h3FFFF, 18'h3FFFF, 18'h3FFFF, i == 4);
    wait_valid(ok);
    checks++;
    if (out_sum2 !== 20'd786417 || out_count2 !== 16'd5) begin
      errors++;
      $display("FAIL wrap20: sum=%0d count=%0d required sum=786417 count=5", out_sum2, out_count2);
    end
    wait_result("wrap");
  endtask

  task automatic test_reset_mid();
    send_beat(18'd100, 18'd100, 18'd100, 1'b0);
    send_beat(18'd100, 18'd100, 18'd100, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    clear_model();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid: valid=%0b ready=%0b required valid=0 ready=1", out_valid, in_ready);
    end
    send_beat(18'd5, 18'd0, 18'd0, 1'b1);
    wait_result("reset_mid");
  endtask

  task automatic test_reset_output();
    bit ok;
    out_ready = 1'b0;
    send_beat(18'd4, 18'd4, 18'd4, 1'b1);
    wait_valid(ok);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    q.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_output cycle %0d: out_valid=%0b required=0", i, out_valid);
      end
      @(posedge clk); #1;
    end
    send_beat(18'd2, 18'd3, 18'd4, 1'b1);
    wait_result("reset_output");
  endtask

  task automatic test_back_to_back();
    fork
      begin
        int prev;
        prev = 0;
        for (int g = 0; g < 4; g++) begin
          send_beat(18'($urandom), 18'($urandom), 18'($urandom), 1'b1);
          if (g > 0) begin
            checks++;
            if (acc_cyc - prev !== 3) begin
              errors++;
              $display("FAIL back_to_back spacing: %0d cycles required 3", acc_cyc - prev);
            end
          end
          prev = acc_cyc;
        end
      end
      begin
        for (int g = 0; g < 4; g++) wait_result("back_to_back");
      end
    join
  endtask

  task automatic test_random();
    int len;
    for (int g = 0; g < 3; g++) begin
      len = $urandom_range(1, 4);
      for (int i = 0; i < len; i++)
        send_beat(18'($urandom), 18'($urandom), 18'($urandom), i == len - 1);
      wait_result("random");
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_idle();
    test_backpressure();
    test_wrap();
    test_reset_mid();
    test_reset_output();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
